mod_sched: RTL and testbench

- Job scheduler in front of the mod engine (copy/encode/decode datapath plus codeout).
- Arbitrates round-robin between NCH DMA channels, each requesting one job with a 24-bit descriptor control word (dc).
- For the granted job: drives dc, pulses the engine reset, holds m_enable, and waits for the engine's active-low end strobe m_endn.
- Returns a per-channel done pulse and frees the engine for the next job.

---
 rtl/mod_pkg.sv | 23 ++
 rtl/mod_rr_arb.sv | 37 +++
 rtl/mod_sched.sv | 198 +++++++++++++++++++
 tb/tb_mod_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared types and constants for the mod engine job scheduler
//
// Purpose: scheduler state encoding and descriptor field positions.
// Ports:   none (package).
package mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    localparam int DC_W       = 24;
    localparam int DC_ENC_BIT = 5;
    localparam int DC_DEC_BIT = 6;

    // True when the descriptor selects the encode or decode path rather than plain copy.
    function automatic logic dc_is_codec(input logic [DC_W-1:0] dc);
        return dc[DC_ENC_BIT] | dc[DC_DEC_BIT];
    endfunction

endpackage

// File: rtl/mod_rr_arb.sv
// rtl/mod_rr_arb.sv - combinational round-robin picker
//
// Purpose: returns the first requester at or above ptr, wrapping past NCH-1 to 0.
// Ports:
//   req_i      NCH  request vector
//   ptr_i      PW   highest-priority channel index
//   win_oh_o   NCH  one-hot winner (0 when no request)
//   win_idx_o  PW   winner index
//   win_vld_o  1    any request present
module mod_rr_arb #(
    parameter int NCH = 4,
    parameter int PW  = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [PW-1:0]  ptr_i,
    output logic [NCH-1:0] win_oh_o,
    output logic [PW-1:0]  win_idx_o,
    output logic           win_vld_o
);

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        win_vld_o = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = int'(ptr_i) + i;
            if (c >= NCH) c = c - NCH;
            if (!win_vld_o && req_i[c]) begin
                win_vld_o   = 1'b1;
                win_oh_o[c] = 1'b1;
                win_idx_o   = PW'(c);
            end
        end
    end

endmodule

// File: rtl/mod_sched.sv
// rtl/mod_sched.sv - round-robin job scheduler in front of the mod engine
//
// Purpose: grants one of NCH channels, latches its descriptor, pulses the engine
//          reset for RST_CYC cycles, runs the engine until m_endn, then acks.
// Optional: MOD_SCHED_TIMEOUT_EN adds a TO_W-bit RUN watchdog that aborts with err.
// Ports:
//   wb_clk_i  1       clock
//   wb_rst_n  1       asynchronous active-low reset
//   req       NCH     per-channel job request (level)
//   req_dc    NCH*24  per-channel descriptors, channel i at [24*i+23:24*i]
//   gnt       NCH     one-hot owner
//   ack       NCH     one-cycle done pulse
//   err       NCH     one-cycle timeout pulse
//   busy      1       engine owned
//   m_reset   1       engine reset, active-high
//   m_enable  1       engine run enable
//   dc        24      descriptor to engine
//   m_endn    1       engine end strobe, active-low
module mod_sched
    import mod_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int RST_CYC = 2,
    parameter int TO_W    = 20
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic [NCH-1:0]      req,
    input  logic [NCH*DC_W-1:0] req_dc,
    output logic [NCH-1:0]      gnt,
    output logic [NCH-1:0]      ack,
    output logic [NCH-1:0]      err,
    output logic                busy,
    output logic                m_reset,
    output logic                m_enable,
    output logic [DC_W-1:0]     dc,
    input  logic                m_endn
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    sched_state_e    state_q, state_d;
    logic [NCH-1:0]  gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
    logic            busy_q, busy_d, m_reset_q, m_reset_d, m_enable_q, m_enable_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic [PW-1:0]   ptr_q, ptr_d, idx_q, idx_d, next_ptr;
    logic [3:0]      rst_cnt_q, rst_cnt_d;

    logic [NCH-1:0]  win_oh;
    logic [PW-1:0]   win_idx;
    logic            win_vld;

`ifdef MOD_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            abort_q, abort_d;
`else
    logic [TO_W-1:0] unused_to;
    assign unused_to = '0;
`endif

    mod_rr_arb #(.NCH(NCH), .PW(PW)) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

    // Owner becomes lowest priority for the next round.
    assign next_ptr = (idx_q == PW'(NCH - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        err_d      = '0;
        m_reset_d  = m_reset_q;
        m_enable_d = m_enable_q;
        dc_d       = dc_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        rst_cnt_d  = rst_cnt_q;
`ifdef MOD_SCHED_TIMEOUT_EN
        wd_d       = wd_q;
        abort_d    = abort_q;
`endif
        case (state_q)
            IDLE: begin
                m_reset_d  = 1'b0;
                m_enable_d = 1'b0;
                if (win_vld) begin
                    gnt_d     = win_oh;
                    idx_d     = win_idx;
                    dc_d      = req_dc[int'(win_idx)*DC_W +: DC_W];
                    rst_cnt_d = 4'(RST_CYC);
                    m_reset_d = 1'b1;
                    state_d   = RST;
                end
            end
            RST: begin
                // m_reset was raised on the edge entering RST, so leaving at
                // count 1 keeps it high for exactly RST_CYC cycles.
                if (rst_cnt_q <= 4'd1) begin
                    m_reset_d = 1'b0;
`ifdef MOD_SCHED_TIMEOUT_EN
                    if (abort_q) begin
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        wd_d       = '0;
                        m_enable_d = 1'b1;
                        state_d    = RUN;
                    end
`else
                    m_enable_d = 1'b1;
                    state_d    = RUN;
`endif
                end else begin
                    rst_cnt_d = rst_cnt_q - 4'd1;
                end
            end
            RUN: begin
                if (!m_endn) begin
                    ack_d      = gnt_q;
                    gnt_d      = '0;
                    ptr_d      = next_ptr;
                    m_enable_d = 1'b0;
                    state_d    = DONE;
                end
`ifdef MOD_SCHED_TIMEOUT_EN
                else if (&wd_q) begin
                    // Hung engine: report err and reset it before freeing it.
                    err_d      = gnt_q;
                    gnt_d      = '0;
                    ptr_d      = next_ptr;
                    m_enable_d = 1'b0;
                    m_reset_d  = 1'b1;
                    rst_cnt_d  = 4'(RST_CYC);
                    abort_d    = 1'b1;
                    state_d    = RST;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            m_reset_q  <= 1'b1;
            m_enable_q <= 1'b0;
            dc_q       <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
            rst_cnt_q  <= '0;
`ifdef MOD_SCHED_TIMEOUT_EN
            wd_q       <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            m_reset_q  <= m_reset_d;
            m_enable_q <= m_enable_d;
            dc_q       <= dc_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            rst_cnt_q  <= rst_cnt_d;
`ifdef MOD_SCHED_TIMEOUT_EN
            wd_q       <= wd_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign m_reset  = m_reset_q;
    assign m_enable = m_enable_q;
    assign dc       = dc_q;

endmodule

// File: tb/tb_mod_sched.sv
// tb/tb_mod_sched.sv - directed self-checking bench for mod_sched
module tb_mod_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [95:0] req_dc = '0;
    logic [3:0]  gnt, ack, err;
    logic        busy, m_reset, m_enable;
    logic [23:0] dc;
    logic        m_endn = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_seen = 0;

    always #5 clk = ~clk;

    mod_sched #(.NCH(4), .RST_CYC(2), .TO_W(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .req      (req),
        .req_dc   (req_dc),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .m_reset  (m_reset),
        .m_enable (m_enable),
        .dc       (dc),
        .m_endn   (m_endn)
    );

    always @(negedge clk) if (ack != 4'b0) ack_seen <= ack_seen + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Entry: at a negedge, DUT in IDLE, req already driven. Exit: at a negedge, DUT in IDLE.
    task automatic job(input logic [3:0] eg, input logic [23:0] edc, input int run_len,
                       input bit drop, input bit glitch, input bit mutate);
        @(negedge clk);
        chk("gnt_at_grant", gnt, eg);
        chk("dc_latched", dc, edc);
        chk("m_reset_rst1", m_reset, 1);
        chk("busy_at_grant", busy, 1);
        if (glitch) m_endn = 1'b0;
        @(negedge clk);
        chk("m_reset_rst2", m_reset, 1);
        chk("m_enable_in_rst", m_enable, 0);
        @(negedge clk);
        m_endn = 1'b1;
        chk("m_enable_run", m_enable, 1);
        chk("m_reset_run", m_reset, 0);
        chk("gnt_run", gnt, eg);
        if (mutate) begin
            req    = req & ~eg;
            req_dc = ~req_dc;
        end
        repeat (run_len - 1) @(negedge clk);
        m_endn = 1'b0;
        @(negedge clk);
        m_endn = 1'b1;
        chk("ack_pulse", ack, eg);
        chk("gnt_cleared", gnt, 0);
        chk("m_enable_done", m_enable, 0);
        chk("err_none", err, 0);
        chk("dc_held", dc, edc);
        if (drop) req = req & ~eg;
        @(negedge clk);
        chk("ack_single", ack, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int acks_before;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_reset", m_reset, 1);
        chk("rst_m_enable", m_enable, 0);
        chk("rst_dc", dc, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("m_reset_released", m_reset, 0);

        // Single job on channel 1
        req = 4'b0010;
        req_dc[47:24] = 24'h000020;
        job(4'b0010, 24'h000020, 10, 1, 0, 0);

        // All four requesting: order 0,1,2,3,0 with wrap
        do_reset();
        for (int i = 0; i < 4; i++) req_dc[24*i +: 24] = 24'h100000 + 24'(i);
        req = 4'b1111;
        job(4'b0001, 24'h100000, 5, 0, 0, 0);
        job(4'b0010, 24'h100001, 5, 0, 0, 0);
        job(4'b0100, 24'h100002, 5, 0, 0, 0);
        job(4'b1000, 24'h100003, 5, 0, 0, 0);
        job(4'b0001, 24'h100000, 5, 1, 0, 0);
        req = 4'b0000;
        @(negedge clk);
        chk("idle_no_req", busy, 0);

        // m_endn glitch during RST is ignored; exactly one ack
        req = 4'b0001;
        req_dc[23:0] = 24'h000040;
        acks_before = ack_seen;
        job(4'b0001, 24'h000040, 3, 1, 1, 0);
        chk("glitch_one_ack", 32'(ack_seen - acks_before), 1);

        // Owner drops req and req_dc changes mid-job
        req = 4'b0100;
        req_dc[71:48] = 24'h000060;
        job(4'b0100, 24'h000060, 4, 1, 0, 1);
        chk("mutate_req_dropped", req, 0);

        // Async reset mid-RUN, ptr now 3; new req in RUN waits
        req_dc = '0;
        req_dc[95:72] = 24'h0000AA;
        req_dc[47:24] = 24'h0000BB;
        req = 4'b1000;
        @(negedge clk);
        chk("ch3_gnt", gnt, 4'b1000);
        repeat (2) @(negedge clk);
        chk("ch3_run", m_enable, 1);
        req = 4'b1010;
        @(negedge clk);
        chk("no_preempt", gnt, 4'b1000);
        acks_before = ack_seen;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m_enable", m_enable, 0);
        chk("arst_m_reset", m_reset, 1);
        chk("arst_gnt", gnt, 0);
        chk("arst_ack", ack, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_no_ack", 32'(ack_seen - acks_before), 0);
        job(4'b0010, 24'h0000BB, 3, 1, 0, 0);

`ifdef MOD_SCHED_TIMEOUT_EN
        // Watchdog: ch3 still pending is granted next; engine never ends
        begin
            bit seen;
            seen = 0;
            @(negedge clk);
            chk("to_gnt", gnt, 4'b1000);
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge clk);
                if (err != 4'b0) seen = 1;
            end
            chk("to_err_seen", 32'(seen), 1);
            chk("to_err", err, 4'b1000);
            chk("to_no_ack", ack, 0);
            chk("to_m_reset1", m_reset, 1);
            chk("to_m_enable", m_enable, 0);
            req = 4'b0001;
            req_dc[23:0] = 24'h0000CC;
            @(negedge clk);
            chk("to_m_reset2", m_reset, 1);
            chk("to_err_single", err, 0);
            @(negedge clk);
            chk("to_idle", busy, 0);
            chk("to_m_reset_off", m_reset, 0);
            @(negedge clk);
            chk("to_next_gnt", gnt, 4'b0001);
        end
`endif

        req = 4'b0000;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
